// File: rtl/rib_master_pkg.sv
// Shared definitions for the RIB bus initiator: wrcs encoding, FSM states,
// default response timeout and the buffered command layout.
package rib_master_pkg;

  localparam logic RIB_WR = 1'b1;
  localparam logic RIB_RD = 1'b0;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CMD_W           = 69;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rib_master_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module rib_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_ONE;
      if (i_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/rib_master.sv
// RIB bus initiator: buffers client commands and runs them one at a time
// through the req/gnt address phase and rsp/rdy response phase.
module rib_master
  import rib_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_cmd_addr,
  input  logic        i_cmd_wr,
  input  logic [3:0]  i_cmd_mask,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_rdata,
  output logic        o_res_err,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic [31:0] i_ribm_rdata,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy,
  output logic        o_busy
);

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  cmd_t        r_cmd;
  cmd_t        w_in_cmd;
  cmd_t        w_head;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_bypass;
  logic        w_fifo_push;
  logic        w_pop;
  logic        w_timeout;

  assign w_in_cmd = '{addr: i_cmd_addr, wr: (i_cmd_wr ? RIB_WR : RIB_RD),
                      mask: i_cmd_mask, wdata: i_cmd_wdata};

  assign o_cmd_ready = !w_full && !i_rst;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  // An idle block with nothing queued loads the command straight into the
  // transaction register so req rises the cycle after the push.
  assign w_bypass    = w_push && (r_state == ST_IDLE) && w_empty;
  assign w_fifo_push = w_push && !w_bypass;
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_RESP) && i_res_ready));
  assign w_timeout   = ({1'b0, r_cnt} + 17'd1) >= TO_LIM;

  rib_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fifo_push),
    .i_data  (w_in_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_bypass || w_pop)          w_next = ST_REQ;
      ST_REQ:  if (i_ribm_gnt)                 w_next = ST_WAIT;
      ST_WAIT: if (i_ribm_rsp || w_timeout)    w_next = ST_RESP;
      ST_RESP: if (i_res_ready)                w_next = w_empty ? ST_IDLE : ST_REQ;
      default:                                 w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_REQ)       r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 16'd1;
      if ((r_state == ST_WAIT) && (i_ribm_rsp || w_timeout)) r_err <= !i_ribm_rsp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_bypass)   r_cmd <= w_in_cmd;
    else if (w_pop) r_cmd <= w_head;
    if (r_state == ST_WAIT) begin
      if (i_ribm_rsp)     r_rdata <= i_ribm_rdata;
      else if (w_timeout) r_rdata <= '0;
    end
  end

  always_comb begin
    o_ribm_req   = 1'b0;
    o_ribm_addr  = '0;
    o_ribm_wrcs  = 1'b0;
    o_ribm_mask  = '0;
    o_ribm_wdata = '0;
    o_ribm_rdy   = 1'b0;
    o_res_valid  = 1'b0;
    o_res_rdata  = '0;
    o_res_err    = 1'b0;
    case (r_state)
      ST_REQ: begin
        o_ribm_req   = 1'b1;
        o_ribm_addr  = r_cmd.addr;
        o_ribm_wrcs  = r_cmd.wr;
        o_ribm_mask  = r_cmd.mask;
        o_ribm_wdata = r_cmd.wdata;
      end
      ST_WAIT: o_ribm_rdy = 1'b1;
      ST_RESP: begin
        o_res_valid = 1'b1;
        o_res_rdata = r_rdata;
        o_res_err   = r_err;
      end
      default: ;
    endcase
  end

  assign o_busy = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_rib_master.sv
// Randomized and directed bench for rib_master against a transaction-level
// model of the command queue, bus phases and completion timeout.
module tb_rib_master;

  localparam int DEPTH = 2;
  localparam int TO    = 8;
  localparam int TO_WAIT = (TO > 1) ? TO - 1 : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_wr, res_ready, gnt, rsp;
  logic [31:0] cmd_addr, cmd_wdata, ribm_rdata;
  logic [3:0]  cmd_mask;

  logic        o_cmd_ready, o_res_valid, o_res_err, o_ribm_wrcs, o_ribm_req;
  logic        o_ribm_rdy, o_busy;
  logic [31:0] o_res_rdata, o_ribm_addr, o_ribm_wdata;
  logic [3:0]  o_ribm_mask;

  always #5 clk = ~clk;

  rib_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wr     (cmd_wr),
    .i_cmd_mask   (cmd_mask),
    .i_cmd_wdata  (cmd_wdata),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (res_ready),
    .o_res_rdata  (o_res_rdata),
    .o_res_err    (o_res_err),
    .o_ribm_addr  (o_ribm_addr),
    .o_ribm_wrcs  (o_ribm_wrcs),
    .o_ribm_mask  (o_ribm_mask),
    .o_ribm_wdata (o_ribm_wdata),
    .o_ribm_req   (o_ribm_req),
    .i_ribm_gnt   (gnt),
    .i_ribm_rdata (ribm_rdata),
    .i_ribm_rsp   (rsp),
    .o_ribm_rdy   (o_ribm_rdy),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } tcmd_t;

  int total = 0;
  int bad   = 0;

  // Model: q holds commands waiting behind the one on the bus; phase 0 =
  // address phase, 1 = awaiting response, 2 = completion offered.
  tcmd_t       q[$];
  tcmd_t       cur;
  bit          have_cur = 1'b0;
  int          phase    = 0;
  longint      cyc      = 0;
  longint      g_cyc    = 0;
  logic [31:0] m_rdata  = '0;
  bit          m_err    = 1'b0;
  logic [32:0] done_q[$];

  function automatic logic [106:0] dut_vec();
    return {o_cmd_ready, o_ribm_req, o_ribm_addr, o_ribm_wrcs, o_ribm_mask,
            o_ribm_wdata, o_ribm_rdy, o_res_valid, o_res_rdata, o_res_err, o_busy};
  endfunction

  function automatic logic [106:0] exp_vec();
    logic req, rv;
    tcmd_t f;
    req = have_cur && (phase == 0);
    rv  = have_cur && (phase == 2);
    f   = req ? cur : '0;
    return {(!rst && (q.size() < DEPTH)), req, f.addr, f.wr, f.mask, f.wdata,
            (have_cur && (phase == 1)), rv, (rv ? m_rdata : 32'h0),
            (rv ? m_err : 1'b0), (have_cur || (q.size() > 0))};
  endfunction

  task automatic step_model();
    bit    was_idle;
    bit    push;
    tcmd_t pc;
    was_idle = !have_cur;
    push     = cmd_valid && (q.size() < DEPTH);
    pc       = '{addr: cmd_addr, wr: cmd_wr, mask: cmd_mask, wdata: cmd_wdata};
    if (have_cur) begin
      case (phase)
        0: if (gnt) begin phase = 1; g_cyc = cyc; end
        1: begin
          if (rsp) begin
            phase = 2; m_rdata = ribm_rdata; m_err = 1'b0;
          end else if (cyc - g_cyc >= TO_WAIT) begin
            phase = 2; m_rdata = '0; m_err = 1'b1;
          end
        end
        default: if (res_ready) begin
          if (q.size() > 0) begin cur = q.pop_front(); phase = 0; end
          else have_cur = 1'b0;
        end
      endcase
    end
    if (push) q.push_back(pc);
    if (was_idle && (q.size() > 0)) begin
      cur = q.pop_front(); have_cur = 1'b1; phase = 0;
    end
  endtask

  always @(negedge clk) begin : cmp_blk
    logic [106:0] e;
    logic [106:0] a;
    if (rst) begin
      q.delete(); have_cur = 1'b0; phase = 0;
    end
    e = exp_vec();
    a = dut_vec();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, a, e);
    end
    if (!rst) begin
      if (o_res_valid && res_ready) done_q.push_back({o_res_err, o_res_rdata});
      step_model();
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic w, input logic [3:0] m,
                         input logic [31:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wr = w; cmd_mask = m; cmd_wdata = d;
  endtask

  initial begin
    int n;
    int dcnt;
    rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_mask = '0;
    cmd_wdata = '0; res_ready = 1'b1; gnt = 0; rsp = 0; ribm_rdata = '0;
    tick(); tick();
    chk("reset_outputs", 128'(dut_vec()), 128'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 128'(o_cmd_ready), 128'h1);

    // Read, immediate grant, response one cycle later
    set_cmd(32'hF100_0004, 1'b0, 4'hF, 32'h0); gnt = 1'b1;
    tick(); cmd_valid = 1'b0;
    chk("rd_req", 128'({o_ribm_req, o_ribm_wrcs, o_ribm_addr}), 128'({1'b1, 1'b0, 32'hF100_0004}));
    tick(); rsp = 1'b1; ribm_rdata = 32'hA5A5_0001;
    chk("rd_rdy", 128'(o_ribm_rdy), 128'h1);
    tick(); rsp = 1'b0; gnt = 1'b0;
    chk("rd_res_lat3", 128'({o_res_valid, o_res_err, o_res_rdata}), 128'({1'b1, 1'b0, 32'hA5A5_0001}));
    tick();

    // Write with grant withheld five cycles
    set_cmd(32'hF200_0000, 1'b1, 4'b0011, 32'h1234_5678);
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("wr_hold", 128'({o_ribm_req, o_ribm_addr, o_ribm_wrcs, o_ribm_mask, o_ribm_wdata}),
          128'({1'b1, 32'hF200_0000, 1'b1, 4'b0011, 32'h1234_5678}));
      if (i == 5) gnt = 1'b1;
      else tick();
    end
    tick(); gnt = 1'b0; rsp = 1'b1; ribm_rdata = 32'h0;
    tick(); rsp = 1'b0;
    chk("wr_res", 128'({o_res_valid, o_res_err}), 128'({1'b1, 1'b0}));
    tick();

    // Timeout, then completion backpressure with a queued command
    set_cmd(32'h0000_0040, 1'b0, 4'hF, 32'h0); gnt = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); gnt = 1'b0; res_ready = 1'b0;
    n = 1;
    while (!o_res_valid && n < 20) begin tick(); n++; end
    chk("timeout_cycles", 128'(n), 128'(TO));
    chk("timeout_res", 128'({o_res_err, o_res_rdata}), 128'({1'b1, 32'h0}));
    rsp = 1'b1; ribm_rdata = 32'h0BAD_0BAD;
    set_cmd(32'h0000_0044, 1'b1, 4'h1, 32'hCAFE_0001);
    for (int i = 0; i < 10; i++) begin
      tick(); cmd_valid = 1'b0; rsp = 1'b0;
      chk("bp_hold", 128'({o_res_valid, o_res_err, o_res_rdata, o_ribm_req, o_busy}),
          128'({1'b1, 1'b1, 32'h0, 1'b0, 1'b1}));
    end
    res_ready = 1'b1;
    tick();
    chk("b2b_req", 128'({o_ribm_req, o_ribm_addr}), 128'({1'b1, 32'h0000_0044}));
    gnt = 1'b1;
    tick(); gnt = 1'b0; rsp = 1'b1; ribm_rdata = 32'h5555_AAAA;
    tick(); rsp = 1'b0;
    chk("after_to_res", 128'({o_res_valid, o_res_err, o_res_rdata}), 128'({1'b1, 1'b0, 32'h5555_AAAA}));
    tick();

    // FIFO full: grant held low, four pushes offered
    for (int i = 0; i < 4; i++) begin
      chk("full_ready", 128'(o_cmd_ready), 128'((i < 3) ? 1 : 0));
      set_cmd(32'h100 + 32'(i * 4), 1'b0, 4'hF, 32'h0);
      tick();
    end
    cmd_valid = 1'b0;
    dcnt = done_q.size();
    gnt = 1'b1; rsp = 1'b1; ribm_rdata = 32'h0000_0077;
    for (int i = 0; i < 15; i++) tick();
    gnt = 1'b0; rsp = 1'b0;
    chk("full_done", 128'(done_q.size() - dcnt), 128'h3);
    chk("full_idle", 128'(o_busy), 128'h0);

    // Asynchronous reset in the middle of the response wait
    set_cmd(32'h0000_0080, 1'b0, 4'hF, 32'h0); gnt = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); gnt = 1'b0;
    chk("pre_rst_wait", 128'(o_ribm_rdy), 128'h1);
    dcnt = done_q.size();
    #1 rst = 1'b1;
    #1 chk("async_rst", 128'(dut_vec()), 128'h0);
    tick(); tick(); rst = 1'b0;
    set_cmd(32'h0000_0084, 1'b0, 4'hF, 32'h0); gnt = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); gnt = 1'b0; rsp = 1'b1; ribm_rdata = 32'h1357_2468;
    tick(); rsp = 1'b0;
    chk("post_rst_res", 128'({o_res_valid, o_res_err, o_res_rdata}), 128'({1'b1, 1'b0, 32'h1357_2468}));
    tick();
    chk("post_rst_done", 128'(done_q.size() - dcnt), 128'h1);
    chk("post_rst_last", 128'(done_q[$]), 128'({1'b0, 32'h1357_2468}));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_addr   = $urandom;
      cmd_wr     = 1'($urandom_range(0, 1));
      cmd_mask   = 4'($urandom_range(0, 15));
      cmd_wdata  = $urandom;
      gnt        = ($urandom_range(0, 9) < 4);
      rsp        = ($urandom_range(0, 9) < 2);
      ribm_rdata = $urandom;
      res_ready  = ($urandom_range(0, 9) < 6);
      if (i == 1500) begin
        #1 rst = 1'b1;
        tick(); rst = 1'b0;
      end else begin
        tick();
      end
    end

    cmd_valid = 1'b0; gnt = 1'b1; rsp = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("drain_idle", 128'(o_busy), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
